// File: rtl/wrap_event_pkg.sv
// Shared types for the wrap event monitor: record layout, FSM states and drop-counter width.
package wrap_event_pkg;
  localparam int W_DEF  = 10;
  localparam int E_DEF  = 4;
  localparam int DROP_W = 8;

  typedef struct packed {
    logic [E_DEF-1:0] epoch;
    logic [W_DEF-1:0] peak;
  } wrap_rec_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mon_state_e;
endpackage

// File: rtl/wrap_event_monitor_if.sv
// Counter sample input, record stream output and status of the wrap event monitor.
interface wrap_event_monitor_if #(
  parameter int W     = 10,
  parameter int E     = 4,
  parameter int DEPTH = 4
);
  import wrap_event_pkg::*;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [W-1:0]      cnt_in;
  logic              cnt_vld;
  logic              out_valid;
  logic              out_ready;
  logic [E-1:0]      out_epoch;
  logic [W-1:0]      out_peak;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic [LVL_W-1:0]  level;

  modport master (
    output cnt_in, cnt_vld, out_ready,
    input  out_valid, out_epoch, out_peak, overflow, drop_cnt, level
  );

  modport slave (
    input  cnt_in, cnt_vld, out_ready,
    output out_valid, out_epoch, out_peak, overflow, drop_cnt, level
  );
endinterface

// File: rtl/wrap_rec_fifo.sv
// Synchronous FIFO for wrap records; pointers carry one extra wrap bit so level = wptr - rptr.
module wrap_rec_fifo
  import wrap_event_pkg::*;
#(
  parameter int REC_W = 14,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [REC_W-1:0] din,
  output logic [REC_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop && !empty;
  // When full, a same-edge pop frees the head slot, which is exactly where wptr points.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/wrap_event_monitor.sv
// Watches the upstream wrap counter, queues {epoch, peak} for each wrap to zero and
// streams the records out on a valid/ready port with drop accounting.
module wrap_event_monitor
  import wrap_event_pkg::*;
#(
  parameter int W     = 10,
  parameter int E     = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  wrap_event_monitor_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [E-1:0] epoch;
    logic [W-1:0] peak;
  } rec_t;
  localparam int REC_W = $bits(rec_t);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

  mon_state_e        state_p0, state_nxt;
  logic [W-1:0]      prev_p0, prev_nxt;
  logic [E-1:0]      epoch_p0, epoch_nxt;
  logic              overflow_p0;
  logic [DROP_W-1:0] drop_cnt_p0;
  logic              wrap;
  logic              pop;
  logic              drop;
  logic              full;
  logic              empty;
  logic              out_valid;
  logic [AW:0]       level;
  rec_t              push_rec;
  rec_t              head_rec;

  always_comb begin
    state_nxt = state_p0;
    prev_nxt  = prev_p0;
    epoch_nxt = epoch_p0;
    wrap      = 1'b0;
    case (state_p0)
      IDLE: begin
        if (bus.cnt_vld && bus.cnt_in != '0) begin
          prev_nxt  = bus.cnt_in;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.cnt_vld) begin
          if (bus.cnt_in != '0) begin
            prev_nxt = bus.cnt_in;
          end else if (prev_p0 != '0) begin
            wrap      = 1'b1;
            prev_nxt  = '0;
            epoch_nxt = epoch_p0 + E'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign push_rec  = '{epoch: epoch_p0, peak: prev_p0};
  assign out_valid = !empty;
  assign pop       = out_valid && bus.out_ready;
  // Epoch still advances on a drop so the consumer sees the gap.
  assign drop      = wrap && full && !pop;

  // Stage p0: monitor state, epoch and drop accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0    <= IDLE;
      prev_p0     <= '0;
      epoch_p0    <= '0;
      overflow_p0 <= 1'b0;
      drop_cnt_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      prev_p0  <= prev_nxt;
      epoch_p0 <= epoch_nxt;
      if (drop) begin
        overflow_p0 <= 1'b1;
        drop_cnt_p0 <= sat_inc(drop_cnt_p0);
      end
    end
  end

  wrap_rec_fifo #(
    .REC_W (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wrap),
    .pop   (pop),
    .din   (push_rec),
    .dout  (head_rec),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.out_valid = out_valid;
  assign bus.out_epoch = empty ? '0 : head_rec.epoch;
  assign bus.out_peak  = empty ? '0 : head_rec.peak;
  assign bus.overflow  = overflow_p0;
  assign bus.drop_cnt  = drop_cnt_p0;
  assign bus.level     = level;

  // Shadow state for the invariants; cleared with the rest of the block.
  logic         ovf_q;
  logic         have_pop;
  logic [E-1:0] last_pop_epoch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q          <= 1'b0;
      have_pop       <= 1'b0;
      last_pop_epoch <= '0;
    end else begin
      ovf_q <= overflow_p0;
      if (pop) begin
        have_pop       <= 1'b1;
        last_pop_epoch <= head_rec.epoch;
      end
    end
  end

  a_level_bound: assert property (@(posedge clk) disable iff (rst) level <= FULL_LVL);
  a_valid_level: assert property (@(posedge clk) disable iff (rst) out_valid == (level != '0));
  a_ovf_sticky:  assert property (@(posedge clk) disable iff (rst) ovf_q |-> overflow_p0);
  a_epoch_seq:   assert property (@(posedge clk) disable iff (rst)
                   (pop && have_pop && !overflow_p0) |-> (head_rec.epoch == last_pop_epoch + E'(1)));

`ifdef FORMAL
  logic past_init = 1'b0;

  always_ff @(posedge clk) begin
    past_init <= 1'b1;
  end

  a_init: assume property (@(posedge clk) !past_init |-> rst);
`endif
endmodule

// File: tb/tb_wrap_event_monitor.sv
// Bench for wrap_event_monitor with W=4, E=3, DEPTH=4.
module tb_wrap_event_monitor;
  localparam int W     = 4;
  localparam int E     = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wrap_event_monitor_if #(.W(W), .E(E), .DEPTH(DEPTH)) bus();

  wrap_event_monitor #(.W(W), .E(E), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [E-1:0] epoch;
    logic [W-1:0] peak;
  } rec_t;

  typedef struct {
    logic         v;
    logic [W-1:0] c;
    logic         r;
    logic         exp_valid;
    int           exp_level;
  } vec_t;

  rec_t sb[$];
  rec_t popped[$];
  vec_t tbl[9];
  int   errors = 0;
  int   checks = 0;

  logic         m_run;
  logic [W-1:0] m_prev;
  logic [E-1:0] m_epoch;
  logic         m_ovf;
  int           m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    popped.delete();
    m_run   = 1'b0;
    m_prev  = '0;
    m_epoch = '0;
    m_ovf   = 1'b0;
    m_drop  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cnt_vld   = 1'b0;
    bus.cnt_in    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive at negedge, check head before the edge, check status after it.
  task automatic step(input logic v, input logic [W-1:0] c, input logic r);
    logic popping;
    logic wrap;
    @(negedge clk);
    bus.cnt_vld   = v;
    bus.cnt_in    = c;
    bus.out_ready = r;
    #1;
    chk("out_valid", bus.out_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("head_epoch", bus.out_epoch, sb[0].epoch);
      chk("head_peak", bus.out_peak, sb[0].peak);
    end
    popping = r && (sb.size() != 0);
    if (popping) begin
      popped.push_back('{bus.out_epoch, bus.out_peak});
      void'(sb.pop_front());
    end
    wrap = 1'b0;
    if (v) begin
      if (!m_run) begin
        if (c != '0) begin
          m_run  = 1'b1;
          m_prev = c;
        end
      end else if (c != '0) begin
        m_prev = c;
      end else if (m_prev != '0) begin
        wrap = 1'b1;
      end
    end
    if (wrap) begin
      if (sb.size() < DEPTH) sb.push_back('{m_epoch, m_prev});
      else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      m_epoch = m_epoch + 3'd1;
      m_prev  = '0;
    end
    @(posedge clk);
    #1;
    chk("level", bus.level, sb.size());
    chk("overflow", bus.overflow, m_ovf);
    chk("drop_cnt", bus.drop_cnt, m_drop);
  endtask

  task automatic run_wrap(input int peak, input logic r);
    for (int i = 1; i <= peak; i++) step(1'b1, W'(i), r);
    step(1'b1, '0, r);
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    bus.cnt_vld   = 1'b0;
    bus.cnt_in    = '0;
    bus.out_ready = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_epoch", bus.out_epoch, 0);
    chk("rst_out_peak", bus.out_peak, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_drop_cnt", bus.drop_cnt, 0);
    chk("rst_level", bus.level, 0);
    rst = 1'b0;

    // Basic wrap, table driven
    for (int i = 0; i < 7; i++) tbl[i] = '{1'b1, W'(i + 1), 1'b1, 1'b0, 0};
    tbl[7] = '{1'b1, 4'd0, 1'b1, 1'b1, 1};
    tbl[8] = '{1'b0, 4'd0, 1'b1, 1'b0, 0};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].c, tbl[i].r);
      chk("tbl_valid", bus.out_valid, tbl[i].exp_valid);
      chk("tbl_level", bus.level, tbl[i].exp_level);
    end
    chk("basic_count", popped.size(), 1);
    chk("basic_epoch", popped[0].epoch, 0);
    chk("basic_peak", popped[0].peak, 7);

    // Backpressure with drops
    do_reset();
    repeat (6) run_wrap(7, 1'b0);
    chk("bp_level", bus.level, 4);
    chk("bp_overflow", bus.overflow, 1);
    chk("bp_drop_cnt", bus.drop_cnt, 2);
    drain(5);
    chk("bp_count", popped.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_epoch", popped[i].epoch, i);
      chk("bp_peak", popped[i].peak, 7);
    end

    // Full FIFO with a pop on the same edge as the wrap
    do_reset();
    repeat (4) run_wrap(7, 1'b0);
    chk("fp_level_before", bus.level, 4);
    for (int i = 1; i <= 7; i++) step(1'b1, W'(i), 1'b0);
    step(1'b1, '0, 1'b1);
    chk("fp_level", bus.level, 4);
    chk("fp_drop_cnt", bus.drop_cnt, 0);
    chk("fp_overflow", bus.overflow, 0);
    drain(5);
    chk("fp_count", popped.size(), 5);
    for (int i = 0; i < 5; i++) chk("fp_epoch", popped[i].epoch, i);

    // Epoch wraps modulo 8
    do_reset();
    repeat (9) run_wrap(2, 1'b1);
    drain(2);
    chk("ew_count", popped.size(), 9);
    for (int i = 0; i < 9; i++) chk("ew_epoch", popped[i].epoch, i % 8);
    chk("ew_overflow", bus.overflow, 0);

    // Leading zeros, invalid cycles and a glitch sample
    do_reset();
    step(1'b1, 4'd0, 1'b1);
    step(1'b0, 4'd5, 1'b1);
    step(1'b1, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    step(1'b1, 4'd3, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    step(1'b1, 4'd0, 1'b1);
    step(1'b1, 4'd0, 1'b1);
    drain(2);
    chk("gap_count", popped.size(), 1);
    chk("gap_epoch", popped[0].epoch, 0);
    chk("gap_peak", popped[0].peak, 3);
    step(1'b1, 4'd5, 1'b1);
    step(1'b1, 4'd2, 1'b1);
    step(1'b1, 4'd0, 1'b1);
    drain(2);
    chk("glitch_count", popped.size(), 2);
    chk("glitch_epoch", popped[1].epoch, 1);
    chk("glitch_peak", popped[1].peak, 2);

    // Asynchronous reset mid-stream
    do_reset();
    run_wrap(3, 1'b0);
    run_wrap(3, 1'b0);
    chk("mr_level_before", bus.level, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_level", bus.level, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_wrap(5, 1'b1);
    drain(2);
    chk("mr_count", popped.size(), 1);
    chk("mr_epoch", popped[0].epoch, 0);
    chk("mr_peak", popped[0].peak, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
